// File: rtl/reg_xfer_sequencer.sv
// reg_xfer_sequencer: expands LOAD/MOVE/SWAP/NOP commands into single-cycle register bank strobes
module reg_xfer_sequencer #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int SCRATCH = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dest,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [ADDR_W-1:0] rf_src,
  output logic [ADDR_W-1:0] rf_dest,
  output logic              rf_move,
  output logic              rf_in,
  output logic [DATA_W-1:0] rf_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [1:0] OP_LOAD = 2'b01, OP_MOVE = 2'b10, OP_SWAP = 2'b11;
  localparam logic [ADDR_W-1:0] SCR = ADDR_W'(SCRATCH);
  typedef enum logic [2:0] {IDLE, S1, S2, S3, FIN} state_t;
  state_t state, state_n;
  logic [1:0] op_q, op;
  logic [ADDR_W-1:0] src_q, dest_q, src, dest, src_n, dest_n;
  logic [DATA_W-1:0] data_q, data, data_n;
  logic accept, bad, move_n, in_n;
  // Outputs are registered from the next state, so the accepting edge uses the live command fields.
  always_comb begin
    accept = cmd_valid && cmd_ready;
    op = accept ? cmd_op : op_q;
    src = accept ? cmd_src : src_q;
    dest = accept ? cmd_dest : dest_q;
    data = accept ? cmd_data : data_q;
    bad = op == OP_SWAP && (src == SCR || dest == SCR);
    state_n = state == IDLE ? (!accept ? IDLE : (op != 2'b00 && !bad) ? S1 : FIN)
            : state == S1   ? (op == OP_SWAP ? S2 : FIN)
            : state == S2   ? S3
            : state == S3   ? FIN
            : IDLE;
    move_n = (state_n == S1 && op != OP_LOAD) || state_n == S2 || state_n == S3;
    in_n = state_n == S1 && op == OP_LOAD;
    src_n = state_n == S1 ? (op == OP_LOAD ? '0 : src)
          : state_n == S2 ? dest
          : state_n == S3 ? SCR
          : '0;
    dest_n = state_n == S1 ? (op == OP_SWAP ? SCR : dest)
           : state_n == S2 ? src
           : state_n == S3 ? dest
           : '0;
    data_n = in_n ? data : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      rf_move <= 1'b0;
      rf_in <= 1'b0;
      rf_src <= '0;
      rf_dest <= '0;
      rf_data <= '0;
      op_q <= '0;
      src_q <= '0;
      dest_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_n;
      cmd_ready <= state_n == IDLE;
      busy <= state_n != IDLE;
      done <= state_n == FIN;
      err <= state_n == FIN && bad;
      rf_move <= move_n;
      rf_in <= in_n;
      rf_src <= src_n;
      rf_dest <= dest_n;
      rf_data <= data_n;
      if (accept) begin
        op_q <= cmd_op;
        src_q <= cmd_src;
        dest_q <= cmd_dest;
        data_q <= cmd_data;
      end
    end
  end
endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// tb_reg_xfer_sequencer: table-driven and randomized checks of the sequencer against a bank-level model
module tb_reg_xfer_sequencer;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_ready;
  logic [1:0] cmd_op = 0;
  logic [2:0] cmd_src = 0, cmd_dest = 0, rf_src, rf_dest;
  logic [15:0] cmd_data = 0, rf_data;
  logic rf_move, rf_in, busy, done, err;
  int n_cmp = 0, n_fail = 0;
  logic [15:0] bank [8];
  logic [15:0] ref_bank [8];

  reg_xfer_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dest(cmd_dest), .cmd_data(cmd_data),
    .rf_src(rf_src), .rf_dest(rf_dest), .rf_move(rf_move), .rf_in(rf_in),
    .rf_data(rf_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 8; i++) bank[i] = 0;
  always @(posedge clk)
    if (rf_move) bank[rf_dest] <= bank[rf_src];
    else if (rf_in) bank[rf_dest] <= rf_data;

  always @(negedge clk) begin
    n_cmp++;
    if (rf_move && rf_in) begin
      n_fail++;
      $display("FAIL move_in_overlap: rf_move=%0b rf_in=%0b required not both 1", rf_move, rf_in);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic mv, in;
    logic [2:0] s, d;
    logic [15:0] data;
  } strobe_t;

  function automatic strobe_t strobe_exp(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d,
                                         input logic [15:0] data, input int i);
    strobe_t r = '0;
    if (op == 2'b01) begin r.in = 1; r.d = d; r.data = data; end
    else if (op == 2'b10) begin r.mv = 1; r.s = s; r.d = d; end
    else if (op == 2'b11) begin
      r.mv = 1;
      r.s = i == 0 ? s : i == 1 ? d : 3'd7;
      r.d = i == 0 ? 3'd7 : i == 1 ? s : d;
    end
    return r;
  endfunction

  task automatic ref_apply(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d, input logic [15:0] data);
    logic [15:0] t;
    if (op == 2'b01) ref_bank[d] = data;
    else if (op == 2'b10) ref_bank[d] = ref_bank[s];
    else if (op == 2'b11 && s != 7 && d != 7) begin
      t = ref_bank[s];
      ref_bank[7] = t;
      ref_bank[s] = ref_bank[d];
      ref_bank[d] = t;
    end
  endtask

  task automatic chk_bank(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_bank_r%0d", tag, i), bank[i], ref_bank[i]);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d, input logic [15:0] data,
                         input bit hold, input bit exp_err, input int exp_n);
    strobe_t e;
    int k = 0;
    while (!cmd_ready && k < 20) begin step(); k++; end
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1; cmd_op = op; cmd_src = s; cmd_dest = d; cmd_data = data;
    step();
    if (hold) begin cmd_op = 2'b01; cmd_dest = 3'd5; cmd_data = 16'hdead; end
    else cmd_valid = 0;
    for (int i = 0; i < exp_n; i++) begin
      e = strobe_exp(op, s, d, data, i);
      chk($sformatf("strobe%0d_move", i), rf_move, e.mv);
      chk($sformatf("strobe%0d_in", i), rf_in, e.in);
      chk($sformatf("strobe%0d_src", i), rf_src, e.s);
      chk($sformatf("strobe%0d_dest", i), rf_dest, e.d);
      chk($sformatf("strobe%0d_data", i), rf_data, e.data);
      chk($sformatf("strobe%0d_done", i), done, 0);
      chk($sformatf("strobe%0d_ready", i), cmd_ready, 0);
      chk($sformatf("strobe%0d_busy", i), busy, 1);
      step();
    end
    cmd_valid = 0;
    chk("fin_done", done, 1);
    chk("fin_err", err, exp_err);
    chk("fin_strobes", {rf_move, rf_in}, 0);
    chk("fin_addr_data", {rf_src, rf_dest, rf_data}, 0);
    chk("fin_busy", busy, 1);
    chk("fin_ready", cmd_ready, 0);
    step();
    chk("post_ready", cmd_ready, 1);
    chk("post_busy_done_err", {busy, done, err}, 0);
    ref_apply(op, s, d, data);
    chk_bank("post");
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] s, d;
    logic [15:0] data;
    bit hold;
    bit exp_err;
    int exp_n;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [1:0] op;
    logic [2:0] s, d;
    bit e;
    for (int i = 0; i < 8; i++) ref_bank[i] = 0;
    vecs[0] = '{2'b01, 3'd0, 3'd0, 16'd9,      0, 0, 1};
    vecs[1] = '{2'b10, 3'd0, 3'd1, 16'd0,      0, 0, 1};
    vecs[2] = '{2'b01, 3'd0, 3'd2, 16'd15,     0, 0, 1};
    vecs[3] = '{2'b11, 3'd2, 3'd0, 16'd0,      0, 0, 3};
    vecs[4] = '{2'b11, 3'd3, 3'd7, 16'd0,      0, 1, 0};
    vecs[5] = '{2'b11, 3'd7, 3'd1, 16'd0,      1, 1, 0};
    vecs[6] = '{2'b11, 3'd4, 3'd4, 16'd0,      0, 0, 3};
    vecs[7] = '{2'b10, 3'd5, 3'd5, 16'd0,      0, 0, 1};
    vecs[8] = '{2'b00, 3'd1, 3'd2, 16'h1234,   1, 0, 0};
    vecs[9] = '{2'b01, 3'd0, 3'd7, 16'hffff,   1, 0, 1};

    step(); step();
    rst = 0;
    chk("reset_ready", cmd_ready, 1);
    chk("reset_busy_done_err", {busy, done, err}, 0);
    chk("reset_strobes", {rf_move, rf_in}, 0);
    chk("reset_addr_data", {rf_src, rf_dest, rf_data}, 0);

    for (int i = 0; i < 10; i++)
      run_cmd(vecs[i].op, vecs[i].s, vecs[i].d, vecs[i].data, vecs[i].hold, vecs[i].exp_err, vecs[i].exp_n);
    chk("table_r0_after_swap", bank[0], 16'd15);
    chk("table_r2_after_swap", bank[2], 16'd9);

    run_cmd(2'b01, 3'd1, 3'd1, 16'haaaa, 0, 0, 1);
    run_cmd(2'b01, 3'd2, 3'd2, 16'h5555, 0, 0, 1);
    cmd_valid = 1; cmd_op = 2'b11; cmd_src = 3'd1; cmd_dest = 3'd2;
    step();
    cmd_valid = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_busy_done_err", {busy, done, err}, 0);
    chk("midrst_strobes", {rf_move, rf_in}, 0);
    chk("midrst_addr_data", {rf_src, rf_dest, rf_data}, 0);
    ref_bank[7] = 16'haaaa;
    ref_bank[1] = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_done", done, 0);
      step();
    end
    chk_bank("midrst");

    cmd_valid = 1; cmd_op = 2'b01; cmd_dest = 3'd3; cmd_data = 16'hbeef; rst = 1;
    step();
    rst = 0; cmd_valid = 0;
    chk("rst_wins_ready", cmd_ready, 1);
    chk("rst_wins_busy", busy, 0);
    step();
    chk("rst_wins_no_strobe", {rf_in, busy}, 0);
    chk_bank("rst_wins");

    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      s = $urandom_range(0, 4) == 0 ? 3'd7 : 3'($urandom_range(0, 7));
      d = $urandom_range(0, 4) == 0 ? 3'd7 : 3'($urandom_range(0, 7));
      e = op == 2'b11 && (s == 3'd7 || d == 3'd7);
      run_cmd(op, s, d, 16'($urandom), 1'($urandom_range(0, 1)), e,
              (op == 2'b00 || e) ? 0 : op == 2'b11 ? 3 : 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
